// File: rtl/cache_refill_ctrl.sv
// Data-cache miss sequencer: writes back a dirty victim line word by word, then refills
// the missing line from word-wide memory over a request/ack handshake.
module cache_refill_ctrl #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req_i,
  input  logic [ADDR_W-1:0]        miss_addr_i,
  input  logic                     victim_dirty_i,
  input  logic [ADDR_W-1:0]        victim_addr_i,
  output logic [LINE_ADDR_LEN-1:0] vic_idx_o,
  input  logic [31:0]              vic_data_i,
  output logic                     fill_we_o,
  output logic [LINE_ADDR_LEN-1:0] fill_idx_o,
  output logic [31:0]              fill_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_rd_req_o,
  output logic                     mem_wr_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     mem_ack_i,
  output logic [31:0]              wb_count_o,
  output logic [31:0]              refill_count_o
);

  localparam int unsigned OffW = LINE_ADDR_LEN + 2;
  localparam logic [ADDR_W-1:0] OffMask = {{(ADDR_W-OffW){1'b0}}, {OffW{1'b1}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWb   = 2'd1;
  localparam logic [1:0] StRf   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0]        line_addr_q, line_addr_d;
  logic [ADDR_W-1:0]        vic_base_q, vic_base_d;
  logic                     dirty_q, dirty_d;
  logic [31:0]              wb_count_q, wb_count_d;
  logic [31:0]              refill_count_q, refill_count_d;

  logic                     last_word;
  logic [ADDR_W-1:0]        word_off;

  assign last_word = &idx_q;
  // Latched bases have their offset bits cleared, so OR-ing in the word offset adds it.
  assign word_off  = {{(ADDR_W-OffW){1'b0}}, idx_q, 2'b00};

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    line_addr_d    = line_addr_q;
    vic_base_d     = vic_base_q;
    dirty_d        = dirty_q;
    wb_count_d     = wb_count_q;
    refill_count_d = refill_count_q;
    case (state_q)
      StIdle: begin
        if (miss_req_i) begin
          line_addr_d = miss_addr_i & ~OffMask;
          vic_base_d  = victim_addr_i & ~OffMask;
          dirty_d     = victim_dirty_i;
          idx_d       = '0;
          state_d     = victim_dirty_i ? StWb : StRf;
        end
      end
      StWb: begin
        if (mem_ack_i) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            idx_d      = '0;
            wb_count_d = wb_count_q + {31'd0, dirty_q};
            state_d    = StRf;
          end
        end
      end
      StRf: begin
        if (mem_ack_i) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            idx_d          = '0;
            refill_count_d = refill_count_q + 32'd1;
            state_d        = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_wr_req_o = 1'b0;
    mem_rd_req_o = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    vic_idx_o    = '0;
    fill_we_o    = 1'b0;
    fill_idx_o   = '0;
    fill_data_o  = '0;
    done_o       = 1'b0;
    case (state_q)
      StWb: begin
        mem_wr_req_o = 1'b1;
        mem_addr_o   = vic_base_q | word_off;
        vic_idx_o    = idx_q;
        mem_wdata_o  = vic_data_i;
      end
      StRf: begin
        mem_rd_req_o = 1'b1;
        mem_addr_o   = line_addr_q | word_off;
        fill_we_o    = mem_ack_i;
        fill_idx_o   = idx_q;
        fill_data_o  = mem_rdata_i;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign wb_count_o     = wb_count_q;
  assign refill_count_o = refill_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      line_addr_q    <= '0;
      vic_base_q     <= '0;
      dirty_q        <= 1'b0;
      wb_count_q     <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      line_addr_q    <= line_addr_d;
      vic_base_q     <= vic_base_d;
      dirty_q        <= dirty_d;
      wb_count_q     <= wb_count_d;
      refill_count_q <= refill_count_d;
    end
  end

endmodule
